lsu_mem_ctrl: RTL and testbench

Load/store controller between the execute stage and the word-addressed data memory (`MemDat`) of the merge-sort RISC-V core. It accepts one byte/half/word load or store request at a time, computes word index and byte lane, and drives the memory's `value`/`esc_mem`/`read_mem`/`dst_mem` port. Sub-word stores are performed as read-modify-write, since the memory only writes full words. Loads are extracted and sign/zero-extended, and a single-cycle response is returned.

---
 rtl/lsu_mem_ctrl_pkg.sv | 30 +++
 rtl/lsu_mem_ctrl_if.sv | 36 +++
 rtl/lsu_mem_ctrl_lane.sv | 42 ++++
 rtl/lsu_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_pkg: shared encodings for the load/store controller.
// Access-size codes, FSM state type, default memory geometry and
// the request legality check used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam int unsigned LSU_MEM_WORDS = 256;
  localparam int unsigned LSU_IDX_W     = 8;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  // True for a misaligned half/word or the reserved size code.
  function automatic logic lsu_bad_req(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SZ_B: lsu_bad_req = 1'b0;
      LSU_SZ_H: lsu_bad_req = off[0];
      LSU_SZ_W: lsu_bad_req = (off != 2'b00);
      default:  lsu_bad_req = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: execute-stage request/response handshake plus the
// word-addressed data memory port. The controller is the slave of the
// request side and the master of the memory side.
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_value;
  logic        mem_esc;
  logic        mem_read;
  logic [31:0] mem_dst;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_value, mem_esc, mem_read, mem_dst
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_value, mem_esc, mem_read, mem_dst
  );

endinterface

// File: rtl/lsu_mem_ctrl_lane.sv
// lsu_lane: combinational byte-lane logic.
// Load path shifts the word down by the byte offset and sign/zero-extends.
// Store path merges byte/half write data into the old word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] lanes;

  // Extract/extend load data and build the lane mask for the store merge.
  always_comb begin
    shifted = word >> {off, 3'b000};
    ld_data = shifted;
    mask    = '1;
    lanes   = wdata;
    case (size)
      LSU_SZ_B: begin
        ld_data = uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask    = 32'h0000_00FF << {off, 3'b000};
        lanes   = {4{wdata[7:0]}};
      end
      LSU_SZ_H: begin
        ld_data = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask    = 32'h0000_FFFF << {off[1], 4'b0000};
        lanes   = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    st_data = (word & ~mask) | (lanes & mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-request-at-a-time load/store controller in front of a
// word-only data memory. Sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (report misaligned and
// reserved-size requests via rsp_err instead of aligning them down).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = LSU_MEM_WORDS,
  parameter int unsigned IDX_W     = LSU_IDX_W
) (
  input  logic           clock,
  input  logic           reset_n,
  lsu_mem_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(MEM_WORDS - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic           req_err;
  logic [1:0]     eff_size;
  logic [1:0]     eff_off;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]    ld_data;
  logic [31:0]    st_data;

  // Decode the incoming request: word index, legality, effective size/offset.
  always_comb begin
    req_idx = bus.req_addr[IDX_W+1:2] & IDX_MASK;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err  = lsu_bad_req(bus.req_size, bus.req_addr[1:0]);
    eff_size = bus.req_size;
    eff_off  = bus.req_addr[1:0];
`else
    req_err  = 1'b0;
    eff_size = (bus.req_size == 2'b11) ? LSU_SZ_W : bus.req_size;
    case (eff_size)
      LSU_SZ_H: eff_off = {bus.req_addr[1], 1'b0};
      LSU_SZ_W: eff_off = 2'b00;
      default:  eff_off = bus.req_addr[1:0];
    endcase
`endif
  end

  lsu_lane u_lane (
    .word    (bus.mem_rdata),
    .off     (off_q),
    .size    (size_q),
    .uns     (uns_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Next-state, register updates and memory/handshake outputs.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    dst_d    = dst_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.mem_read  = 1'b0;
    bus.mem_esc   = 1'b0;
    // Idle write-back of the addressed word keeps an always-writing memory unchanged.
    bus.mem_value = bus.mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = eff_size;
          uns_d   = bus.req_unsigned;
          off_d   = eff_off;
          wdata_d = bus.req_wdata;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            dst_d   = {{(32-IDX_W){1'b0}}, req_idx};
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (!we_q) begin
          bus.mem_read = 1'b1;
          rdata_d      = ld_data;
          state_d      = ST_RESP;
        end else if (size_q == LSU_SZ_W) begin
          bus.mem_esc   = 1'b1;
          bus.mem_value = wdata_q;
          state_d       = ST_RESP;
        end else begin
          bus.mem_read = 1'b1;
          merged_d     = st_data;
          state_d      = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        bus.mem_esc   = 1'b1;
        bus.mem_value = merged_q;
        state_d       = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      dst_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      dst_q    <= dst_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // err_q can only be set when the trap feature is built in.
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_dst   = dst_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: behavioural always-writing word memory,
// scoreboard queue of expected responses, one task per scenario.
// Honours LSU_MISALIGN_TRAP_EN for the misalignment expectations.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clock = ~clock;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.MEM_WORDS(256), .IDX_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [31:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_dst[7:0]];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      mem[bus.mem_dst[7:0]] <= bus.mem_value;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nacc;
  } exp_t;

  typedef struct {
    logic        got;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nacc;
    int          esc_k;
    logic        ready_ok;
    logic        after_ok;
  } obs_t;

  exp_t exp_q[$];

  task automatic do_req(input req_t r, output obs_t o);
    int g;
    o.got = 1'b0; o.lat = 0; o.rdata = '0; o.err = 1'b0;
    o.nacc = 0; o.esc_k = 0; o.ready_ok = 1'b1; o.after_ok = 1'b0;
    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_we       = r.we;
    bus.req_size     = r.size;
    bus.req_unsigned = r.uns;
    bus.req_addr     = r.addr;
    bus.req_wdata    = r.wdata;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin
      @(negedge clock);
      g++;
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (bus.req_ready !== 1'b0) o.ready_ok = 1'b0;
      if (bus.mem_read === 1'b1 || bus.mem_esc === 1'b1) o.nacc++;
      if (bus.mem_esc === 1'b1) o.esc_k = k;
      if (bus.rsp_valid === 1'b1) begin
        o.got = 1'b1; o.lat = k; o.rdata = bus.rsp_rdata; o.err = bus.rsp_err;
        break;
      end
    end
    @(negedge clock);
    o.after_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset rsp_err: got %b want 0", bus.rsp_err); end
    n_tests++; if (bus.mem_esc !== 1'b0) begin n_fail++; $display("FAIL reset mem_esc: got %b want 0", bus.mem_esc); end
    n_tests++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset mem_read: got %b want 0", bus.mem_read); end
    n_tests++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_tests++; if (bus.mem_value !== 32'h0) begin n_fail++; $display("FAIL reset mem_value: got %h want 0", bus.mem_value); end
    n_tests++; if (bus.mem_dst !== 32'h0) begin n_fail++; $display("FAIL reset mem_dst: got %h want 0", bus.mem_dst); end
  endtask

  task automatic test_word();
    req_t r [2];
    exp_t x [2];
    obs_t o;
    exp_t e;
    r[0] = '{1'b1, LSU_SZ_W, 1'b0, 32'h10, 32'hDEADBEEF}; x[0] = '{32'h0, 1'b0, 2, 1};
    r[1] = '{1'b0, LSU_SZ_W, 1'b0, 32'h10, 32'h0};        x[1] = '{32'hDEADBEEF, 1'b0, 2, 1};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(x[i]);
      do_req(r[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o.got !== 1'b1) begin n_fail++; $display("FAIL word[%0d] rsp_valid: none within bound", i); end
      else begin
        n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL word[%0d] latency: got %0d want %0d", i, o.lat, e.lat); end
        n_tests++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL word[%0d] rsp: got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
        n_tests++; if (o.nacc != e.nacc || !o.ready_ok || !o.after_ok) begin n_fail++; $display("FAIL word[%0d] handshake: acc %0d want %0d ready_ok %b after_ok %b", i, o.nacc, e.nacc, o.ready_ok, o.after_ok); end
      end
    end
    n_tests++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word mem[4]: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_byte_rmw();
    req_t r [2];
    exp_t x [2];
    obs_t o;
    exp_t e;
    r[0] = '{1'b1, LSU_SZ_W, 1'b0, 32'h10, 32'h11223344}; x[0] = '{32'h0, 1'b0, 2, 1};
    r[1] = '{1'b1, LSU_SZ_B, 1'b0, 32'h12, 32'hFFFFFFAA}; x[1] = '{32'h0, 1'b0, 3, 2};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(x[i]);
      do_req(r[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o.got !== 1'b1) begin n_fail++; $display("FAIL rmw[%0d] rsp_valid: none within bound", i); end
      else begin
        n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL rmw[%0d] latency: got %0d want %0d", i, o.lat, e.lat); end
        n_tests++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL rmw[%0d] rsp: got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
        n_tests++; if (o.nacc != e.nacc || !o.ready_ok || !o.after_ok) begin n_fail++; $display("FAIL rmw[%0d] handshake: acc %0d want %0d ready_ok %b after_ok %b", i, o.nacc, e.nacc, o.ready_ok, o.after_ok); end
      end
    end
    n_tests++; if (o.esc_k != 2) begin n_fail++; $display("FAIL rmw esc_cycle: got %0d want 2", o.esc_k); end
    n_tests++; if (mem[4] !== 32'h11AA3344) begin n_fail++; $display("FAIL rmw mem[4]: got %h want 11aa3344", mem[4]); end
  endtask

  task automatic test_load_ext();
    req_t r [9];
    exp_t x [9];
    obs_t o;
    exp_t e;
    r[0] = '{1'b1, LSU_SZ_W, 1'b0, 32'h10, 32'h80FF7F01}; x[0] = '{32'h0,        1'b0, 2, 1};
    r[1] = '{1'b0, LSU_SZ_B, 1'b0, 32'h13, 32'h0};        x[1] = '{32'hFFFFFF80, 1'b0, 2, 1};
    r[2] = '{1'b0, LSU_SZ_B, 1'b1, 32'h13, 32'h0};        x[2] = '{32'h00000080, 1'b0, 2, 1};
    r[3] = '{1'b0, LSU_SZ_H, 1'b0, 32'h12, 32'h0};        x[3] = '{32'hFFFF80FF, 1'b0, 2, 1};
    r[4] = '{1'b0, LSU_SZ_H, 1'b1, 32'h10, 32'h0};        x[4] = '{32'h00007F01, 1'b0, 2, 1};
    r[5] = '{1'b0, LSU_SZ_B, 1'b0, 32'h11, 32'h0};        x[5] = '{32'h0000007F, 1'b0, 2, 1};
    r[6] = '{1'b1, LSU_SZ_H, 1'b0, 32'h12, 32'h1234BEEF}; x[6] = '{32'h0,        1'b0, 3, 2};
    r[7] = '{1'b0, LSU_SZ_W, 1'b0, 32'h10, 32'h0};        x[7] = '{32'hBEEF7F01, 1'b0, 2, 1};
    r[8] = '{1'b0, LSU_SZ_H, 1'b0, 32'h12, 32'h0};        x[8] = '{32'hFFFFBEEF, 1'b0, 2, 1};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(x[i]);
      do_req(r[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o.got !== 1'b1) begin n_fail++; $display("FAIL ext[%0d] rsp_valid: none within bound", i); end
      else begin
        n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL ext[%0d] latency: got %0d want %0d", i, o.lat, e.lat); end
        n_tests++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL ext[%0d] rsp: got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
        n_tests++; if (o.nacc != e.nacc || !o.ready_ok || !o.after_ok) begin n_fail++; $display("FAIL ext[%0d] handshake: acc %0d want %0d ready_ok %b after_ok %b", i, o.nacc, e.nacc, o.ready_ok, o.after_ok); end
      end
    end
  endtask

  task automatic test_misalign();
    req_t r [5];
    exp_t x [5];
    obs_t o;
    exp_t e;
    logic [31:0] exp_mem4;
    r[0] = '{1'b1, LSU_SZ_W, 1'b0, 32'h10, 32'hCAFEF00D}; x[0] = '{32'h0, 1'b0, 2, 1};
    r[1] = '{1'b0, LSU_SZ_W, 1'b0, 32'h11, 32'h0};
    r[2] = '{1'b0, LSU_SZ_H, 1'b0, 32'h13, 32'h0};
    r[3] = '{1'b0, 2'b11,    1'b0, 32'h10, 32'h0};
    r[4] = '{1'b1, LSU_SZ_W, 1'b0, 32'h13, 32'h01234567};
`ifdef LSU_MISALIGN_TRAP_EN
    x[1] = '{32'h0, 1'b1, 1, 0};
    x[2] = '{32'h0, 1'b1, 1, 0};
    x[3] = '{32'h0, 1'b1, 1, 0};
    x[4] = '{32'h0, 1'b1, 1, 0};
    exp_mem4 = 32'hCAFEF00D;
`else
    x[1] = '{32'hCAFEF00D, 1'b0, 2, 1};
    x[2] = '{32'hFFFFCAFE, 1'b0, 2, 1};
    x[3] = '{32'hCAFEF00D, 1'b0, 2, 1};
    x[4] = '{32'h0,        1'b0, 2, 1};
    exp_mem4 = 32'h01234567;
`endif
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(x[i]);
      do_req(r[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o.got !== 1'b1) begin n_fail++; $display("FAIL mis[%0d] rsp_valid: none within bound", i); end
      else begin
        n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL mis[%0d] latency: got %0d want %0d", i, o.lat, e.lat); end
        n_tests++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL mis[%0d] rsp: got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
        n_tests++; if (o.nacc != e.nacc || !o.ready_ok || !o.after_ok) begin n_fail++; $display("FAIL mis[%0d] handshake: acc %0d want %0d ready_ok %b after_ok %b", i, o.nacc, e.nacc, o.ready_ok, o.after_ok); end
      end
    end
    n_tests++; if (mem[4] !== exp_mem4) begin n_fail++; $display("FAIL mis mem[4]: got %h want %h", mem[4], exp_mem4); end
  endtask

  task automatic test_wrap();
    req_t r [2];
    exp_t x [2];
    obs_t o;
    exp_t e;
    r[0] = '{1'b1, LSU_SZ_W, 1'b0, 32'h400, 32'h5A5A1234}; x[0] = '{32'h0,        1'b0, 2, 1};
    r[1] = '{1'b0, LSU_SZ_W, 1'b0, 32'h000, 32'h0};        x[1] = '{32'h5A5A1234, 1'b0, 2, 1};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(x[i]);
      do_req(r[i], o);
      e = exp_q.pop_front();
      n_tests++;
      if (o.got !== 1'b1) begin n_fail++; $display("FAIL wrap[%0d] rsp_valid: none within bound", i); end
      else begin
        n_tests++; if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin n_fail++; $display("FAIL wrap[%0d] rsp: got %h/%b lat %0d want %h/%b lat %0d", i, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat); end
      end
    end
    n_tests++; if (mem[0] !== 32'h5A5A1234) begin n_fail++; $display("FAIL wrap mem[0]: got %h want 5a5a1234", mem[0]); end
  endtask

  task automatic test_reset_mid();
    req_t r;
    obs_t o;
    logic seen_esc;
    logic seen_rsp;
    r = '{1'b1, LSU_SZ_W, 1'b0, 32'h10, 32'h11223344};
    do_req(r, o);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = LSU_SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h11; bus.req_wdata = 32'h55;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    seen_esc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.mem_esc === 1'b1) begin seen_esc = 1'b1; break; end
    end
    n_tests++; if (seen_esc !== 1'b1) begin n_fail++; $display("FAIL rstmid esc_seen: got %b want 1", seen_esc); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (bus.mem_esc !== 1'b0) begin n_fail++; $display("FAIL rstmid mem_esc: got %b want 0", bus.mem_esc); end
    seen_rsp = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    n_tests++; if (seen_rsp !== 1'b0) begin n_fail++; $display("FAIL rstmid rsp_valid: got pulse want none"); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid req_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (mem[4] !== 32'h11223344) begin n_fail++; $display("FAIL rstmid mem[4]: got %h want 11223344", mem[4]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    reset_n = 1'b0;
    mem_clr = 1'b1;
    repeat (3) @(posedge clock);
    test_reset();
    reset_n = 1'b1;
    mem_clr = 1'b0;
    test_word();
    test_byte_rmw();
    test_load_ext();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
